// File: rtl/cachebus_mem_responder.sv
// cachebus_mem_responder
// Responder end of the cachebus for the memory stage. It accepts one
// word-sized read or write at a time and services it from an internal
// word-addressed SRAM. After a programmable latency it raises a one-cycle
// response. Every output is registered.

module cachebus_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,   // power of 2, >= 2
    parameter int unsigned LATENCY     = 2,      // >= 1
    parameter logic [31:0] BASE_ADDR   = 32'h0   // 4-byte aligned
) (
    input  logic        clk,
    input  logic        rst,        // asynchronous, active-low
    input  logic [31:0] addr_i,
    input  logic        read_i,
    input  logic        write_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  wmask_i,
    output logic [31:0] rdata_o,
    output logic        resp_v_o,
    output logic        err_o,
    output logic        busy_o
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;

    // Request captured at the accept edge
    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;
    logic [3:0]         r_wmask;
    logic               r_read;
    logic               r_write;

    // Registered outputs
    logic [31:0]        r_rdata;
    logic               r_resp_v;
    logic               r_err;
    logic               r_busy;

    logic [31:0]        r_mem [DEPTH_WORDS];

    // The request that is in service. In IDLE this is the live request,
    // because with LATENCY=1 the accept edge is also the edge entering RESP.
    logic [31:0]        w_sel_addr;
    logic [31:0]        w_sel_wdata;
    logic [3:0]         w_sel_wmask;
    logic               w_sel_read;
    logic               w_sel_write;
    logic [31:0]        w_off;
    logic [IDX_W-1:0]   w_idx;
    logic               w_err;
    logic               w_req;
    logic               w_enter_resp;
    logic               w_mem_we;
    logic [31:0]        w_resp_rdata;

    assign w_req       = read_i | write_i;
    assign w_sel_addr  = (r_state == ST_IDLE) ? addr_i  : r_addr;
    assign w_sel_wdata = (r_state == ST_IDLE) ? wdata_i : r_wdata;
    assign w_sel_wmask = (r_state == ST_IDLE) ? wmask_i : r_wmask;
    assign w_sel_read  = (r_state == ST_IDLE) ? read_i  : r_read;
    assign w_sel_write = (r_state == ST_IDLE) ? write_i : r_write;

    // Address decode relative to BASE_ADDR. The subtraction wraps at 32 bits,
    // so an address below the base lands far out of range.
    assign w_off = w_sel_addr - BASE_ADDR;
    assign w_idx = w_off[IDX_W+1:2];
    assign w_err = (w_off[1:0] != 2'b00)
                 | ((w_off >> 2) >= 32'(DEPTH_WORDS))
                 | (w_sel_read & w_sel_write);

    assign w_enter_resp = ((r_state == ST_IDLE) && w_req && (LATENCY == 1))
                        | ((r_state == ST_WAIT) && (r_cnt == CNT_W'(1)));

    // NOTE: the write enable is gated with rst. In reset the FSM sits in IDLE,
    // and with LATENCY=1 a held request would otherwise commit during reset.
    assign w_mem_we = rst & w_enter_resp & w_sel_write & ~w_err;

    assign w_resp_rdata = (w_sel_read && !w_err) ? r_mem[w_idx] : 32'h0;

    // Byte-masked SRAM write, committed at the edge entering RESP
    // NOTE: the storage array has no reset. Its contents survive rst, and
    // without a reset it can map onto RAM resources.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_sel_wmask[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_sel_wdata[8*b +: 8];
                end
            end
        end
    end

    // Access FSM: accept -> optional wait -> one-cycle response
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_wmask  <= '0;
            r_read   <= 1'b0;
            r_write  <= 1'b0;
            r_rdata  <= '0;
            r_resp_v <= 1'b0;
            r_err    <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_resp_v <= 1'b0;
                    r_err    <= 1'b0;
                    r_rdata  <= '0;
                    r_busy   <= 1'b0;
                    if (w_req) begin
                        r_addr  <= addr_i;
                        r_wdata <= wdata_i;
                        r_wmask <= wmask_i;
                        r_read  <= read_i;
                        r_write <= write_i;
                        r_busy  <= 1'b1;
                        if (LATENCY == 1) begin
                            r_state  <= ST_RESP;
                            r_resp_v <= 1'b1;
                            r_err    <= w_err;
                            r_rdata  <= w_resp_rdata;
                        end else begin
                            r_state <= ST_WAIT;
                            r_cnt   <= CNT_W'(LATENCY - 1);
                        end
                    end
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state  <= ST_RESP;
                        r_resp_v <= 1'b1;
                        r_err    <= w_err;
                        r_rdata  <= w_resp_rdata;
                    end
                end
                ST_RESP: begin
                    r_state  <= ST_IDLE;
                    r_resp_v <= 1'b0;
                    r_err    <= 1'b0;
                    r_rdata  <= '0;
                    r_busy   <= 1'b0;
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_resp_v <= 1'b0;
                    r_err    <= 1'b0;
                    r_rdata  <= '0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign rdata_o  = r_rdata;
    assign resp_v_o = r_resp_v;
    assign err_o    = r_err;
    assign busy_o   = r_busy;

endmodule
